// File: rtl/iram_load_ctrl.sv
// iram_load_ctrl: loads the instruction RAM from a byte stream, zero-fills the rest, stalls the CPU meanwhile
module iram_load_ctrl #(
  parameter int AW = 7,
  parameter int DW = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic [7:0]    LEN,
  input  logic [7:0]    BYTE_DATA,
  input  logic          BYTE_VALID,
  output logic          BYTE_READY,
  input  logic          ABORT,
  input  logic [7:0]    CPU_ADDR,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_WDATA,
  output logic          CPU_HOLD,
  output logic          DONE,
  output logic          ERR,
  output logic [7:0]    WCOUNT
);
  localparam int BW = DW / 2;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HI   = 3'd1;
  localparam logic [2:0] S_LO   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_FILL = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;
  logic [2:0]    state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    wcount_q, wcount_d;
  logic          err_q, err_d;
  logic [BW-1:0] hi_q, hi_d, lo_q, lo_d;
  logic          idle, len_ok, last, full, unused_addr_lsb;
  assign unused_addr_lsb = CPU_ADDR[0];
  assign idle   = state_q == S_IDLE;
  assign len_ok = LEN != 8'd0 && {1'b0, LEN} <= 9'(2 ** AW);
  assign last   = 8'(wptr_q) == len_q - 8'd1;
  assign full   = {1'b0, len_q} == 9'(2 ** AW);
  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    len_d    = len_q;
    wcount_d = wcount_q;
    err_d    = err_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (!idle && ABORT) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (START) begin
          if (len_ok) begin
            len_d    = LEN;
            wptr_d   = '0;
            wcount_d = '0;
            err_d    = 1'b0;
            state_d  = S_HI;
          end else err_d = 1'b1;
        end
        S_HI: if (BYTE_VALID) begin
          hi_d    = BYTE_DATA;
          state_d = S_LO;
        end
        S_LO: if (BYTE_VALID) begin
          lo_d    = BYTE_DATA;
          state_d = S_WR;
        end
        S_WR: begin
          wcount_d = wcount_q + 8'd1;
          if (last && full) state_d = S_FIN;
          else begin
            wptr_d  = wptr_q + 1'b1;
            state_d = last ? S_FILL : S_HI;
          end
        end
        S_FILL: begin
          // wptr parks on the top word so FINISH still addresses it
          if (&wptr_q) state_d = S_FIN;
          else wptr_d = wptr_q + 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      wptr_q   <= '0;
      len_q    <= '0;
      wcount_q <= '0;
      err_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      len_q    <= len_d;
      wcount_q <= wcount_d;
      err_q    <= err_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end
  assign BYTE_READY = state_q == S_HI || state_q == S_LO;
  assign MEM_WE     = (state_q == S_WR || state_q == S_FILL) && !ABORT;
  assign MEM_WDATA  = state_q == S_WR ? {hi_q, lo_q} : '0;
  assign MEM_ADDR   = idle ? CPU_ADDR[AW:1] : wptr_q;
  assign CPU_HOLD   = !idle;
  assign DONE       = state_q == S_FIN && !ABORT;
  assign ERR        = err_q;
  assign WCOUNT     = wcount_q;
endmodule

// File: tb/tb_iram_load_ctrl.sv
// tb_iram_load_ctrl: directed + randomized loads checked against a word-level model of the loaded RAM image
module tb_iram_load_ctrl;
  logic        CLK = 1'b0, RESET = 1'b1, START = 1'b0, BYTE_VALID = 1'b0, ABORT = 1'b0;
  logic [7:0]  LEN = '0, BYTE_DATA = '0, CPU_ADDR = '0, WCOUNT;
  logic        BYTE_READY, MEM_WE, CPU_HOLD, DONE, ERR;
  logic [6:0]  MEM_ADDR;
  logic [15:0] MEM_WDATA;
  logic [15:0] ram [128];
  logic [6:0]  wlog [4096];
  logic [7:0]  stream [256];
  int wr_cnt = 0;
  int tests = 0, fails = 0, base = 0;

  iram_load_ctrl #(.AW(7), .DW(16)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .LEN(LEN), .BYTE_DATA(BYTE_DATA),
    .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY), .ABORT(ABORT), .CPU_ADDR(CPU_ADDR),
    .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA), .CPU_HOLD(CPU_HOLD),
    .DONE(DONE), .ERR(ERR), .WCOUNT(WCOUNT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (MEM_WE) begin
    ram[MEM_ADDR] <= MEM_WDATA;
    wlog[wr_cnt % 4096] <= MEM_ADDR;
    wr_cnt <= wr_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input int i, input int len);
    return i < len ? {stream[2*i], stream[2*i+1]} : 16'h0000;
  endfunction

  task automatic rnd_stream();
    for (int i = 0; i < 256; i++) stream[i] = 8'($urandom);
  endtask

  task automatic tick(input logic v, input logic [7:0] d, input logic a);
    BYTE_VALID = v; BYTE_DATA = d; ABORT = a;
    @(negedge CLK);
  endtask

  task automatic bad_start(input int len);
    int b;
    b = wr_cnt;
    START = 1'b1; LEN = 8'(len);
    @(negedge CLK);
    START = 1'b0;
    chk($sformatf("bad_len%0d_err", len), ERR, 1);
    chk($sformatf("bad_len%0d_hold", len), CPU_HOLD, 0);
    chk($sformatf("bad_len%0d_ready", len), BYTE_READY, 0);
    repeat (3) @(negedge CLK);
    chk($sformatf("bad_len%0d_writes", len), wr_cnt - b, 0);
    chk($sformatf("bad_len%0d_hold_later", len), CPU_HOLD, 0);
  endtask

  // mode 0: continuous valid, 1: valid every other cycle, 2: random valid
  task automatic load(input int len, input int mode, input int stop_at);
    int bi, cyc, b, dcyc, bad, badaddr;
    logic [6:0] fin_addr;
    bi = 0; cyc = 0; dcyc = -1; b = wr_cnt; bad = 0; badaddr = 0; fin_addr = '0;
    START = 1'b1; LEN = 8'(len);
    @(negedge CLK);
    START = 1'b0; LEN = 8'($urandom);
    cyc = 1;
    while (cyc < 1000 && !(stop_at > 0 && cyc >= stop_at)) begin
      if (DONE) begin
        dcyc = cyc;
        fin_addr = MEM_ADDR;
        break;
      end
      BYTE_VALID = mode == 0 ? 1'b1 : mode == 1 ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      BYTE_DATA = stream[bi % 256];
      if (BYTE_VALID && BYTE_READY) bi++;
      @(negedge CLK);
      cyc++;
    end
    BYTE_VALID = 1'b0;
    if (stop_at > 0) return;
    if (mode == 0) chk($sformatf("len%0d_done_cycle", len), dcyc, 3 * len + (128 - len) + 1);
    else chk($sformatf("len%0d_done_seen", len), dcyc > 0, 1);
    chk($sformatf("len%0d_bytes_taken", len), bi, 2 * len);
    chk($sformatf("len%0d_wcount", len), WCOUNT, len);
    chk($sformatf("len%0d_err", len), ERR, 0);
    chk($sformatf("len%0d_final_addr", len), fin_addr, 127);
    chk($sformatf("len%0d_writes", len), wr_cnt - b, 128);
    for (int i = 0; i < 128; i++) begin
      if (ram[i] !== exp_word(i, len)) bad++;
      if (wlog[(b + i) % 4096] !== 7'(i)) badaddr++;
    end
    chk($sformatf("len%0d_ram_words_wrong", len), bad, 0);
    chk($sformatf("len%0d_addr_order_wrong", len), badaddr, 0);
    @(negedge CLK);
    chk($sformatf("len%0d_hold_after_done", len), CPU_HOLD, 0);
    chk($sformatf("len%0d_done_one_cycle", len), DONE, 0);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_ready", BYTE_READY, 0);
    chk("rst_hold", CPU_HOLD, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_wcount", WCOUNT, 0);
    chk("rst_we", MEM_WE, 0);
    RESET = 1'b0;
    base = wr_cnt;
    @(negedge CLK);
    chk("post_rst_writes", wr_cnt - base, 0);

    CPU_ADDR = 8'h3A; #1;
    chk("idle_addr_3a", MEM_ADDR, 7'h1D);
    chk("idle_we", MEM_WE, 0);
    for (int i = 0; i < 4; i++) begin
      CPU_ADDR = 8'($urandom); #1;
      chk("idle_addr_rnd", MEM_ADDR, CPU_ADDR >> 1);
    end
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    chk("idle_abort_ignored", ERR, 0);

    bad_start(0);

    for (int i = 0; i < 256; i++) stream[i] = 8'h00;
    {stream[0], stream[1], stream[2], stream[3], stream[4], stream[5]} = 48'hF001_517F_2A7A;
    load(3, 0, 0);
    chk("len3_word0", ram[0], 16'hF001);
    chk("len3_word2", ram[2], 16'h2A7A);

    bad_start(200);

    rnd_stream();
    load(128, 0, 0);

    rnd_stream();
    load(2, 1, 0);

    rnd_stream();
    base = wr_cnt;
    START = 1'b1; LEN = 8'd4;
    @(negedge CLK);
    START = 1'b0;
    tick(1'b1, stream[0], 1'b0);
    tick(1'b1, stream[1], 1'b0);
    chk("abort_word0_we", MEM_WE, 1);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, stream[2], 1'b0);
    chk("abort_ready_lo", BYTE_READY, 1);
    BYTE_VALID = 1'b1; BYTE_DATA = stream[3]; ABORT = 1'b1; #1;
    chk("abort_no_we", MEM_WE, 0);
    chk("abort_no_done", DONE, 0);
    @(negedge CLK);
    ABORT = 1'b0; BYTE_VALID = 1'b0;
    chk("abort_hold", CPU_HOLD, 0);
    chk("abort_err", ERR, 1);
    chk("abort_word0", ram[0], {stream[0], stream[1]});
    repeat (3) @(negedge CLK);
    chk("abort_writes", wr_cnt - base, 1);
    chk("abort_err_sticky", ERR, 1);

    rnd_stream();
    load(1, 2, 0);

    for (int k = 0; k < 3; k++) begin
      rnd_stream();
      load($urandom_range(1, 128), $urandom_range(0, 2), 0);
    end

    rnd_stream();
    load(5, 0, 20);
    chk("fill_we", MEM_WE, 1);
    chk("fill_wdata", MEM_WDATA, 0);
    #2 RESET = 1'b1;
    #1;
    chk("amid_rst_we", MEM_WE, 0);
    chk("amid_rst_hold", CPU_HOLD, 0);
    chk("amid_rst_ready", BYTE_READY, 0);
    chk("amid_rst_wcount", WCOUNT, 0);
    chk("amid_rst_err", ERR, 0);
    base = wr_cnt;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (5) @(negedge CLK);
    chk("amid_rst_writes", wr_cnt - base, 0);
    chk("amid_rst_hold_later", CPU_HOLD, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
